pe_mac_pipe: RTL and testbench

PE_MAC_PIPE -- requirements
Module: pe_mac_pipe

---
 rtl/pe_mac_pipe.sv | 133 +++++++++++++
 tb/tb_pe_mac_pipe.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pe_mac_pipe.sv
// Pipelined multi-channel signed MAC: per-tap products, adder tree, group
// accumulator, then round/ReLU/saturate into a held result register.
module pe_mac_lane #(
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    output logic signed [2*DATA_W-1:0] prod
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  prod <= '0;
        else if (en) prod <= a * b;
    end
endmodule

module pe_mac_pipe #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 9,
    parameter int CH     = 2,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 8,
    parameter int ROU    = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [DATA_W*TAPS*CH-1:0]   i_image,
    input  logic [DATA_W*TAPS*CH-1:0]   i_kernel,
    input  logic                        i_last,
    input  logic                        i_relu,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [ACC_W-1:0]     o_acc,
    output logic signed [OUT_W-1:0]     o_data,
    output logic                        o_sat
);
    localparam int N  = TAPS * CH;
    localparam int PW = 2 * DATA_W;
    localparam int RW = ACC_W + 1;
    localparam logic signed [RW-1:0] OMAX = (RW'(1) << (OUT_W - 1)) - RW'(1);
    localparam logic signed [RW-1:0] OMIN = ~OMAX;

    logic                    adv;
    logic [2:1]              vld_pipe, last_pipe, relu_pipe;
    logic signed [PW-1:0]    prod [N];
    logic signed [ACC_W-1:0] prod_sum, sum_q, acc, acc_next;
    logic                    first;
    logic signed [RW-1:0]    acc_ext, rnd, rr;
    logic signed [OUT_W-1:0] sat_val;
    logic                    sat_hit;
    logic                    res_load;

    // A pending, unaccepted result freezes every stage.
    assign adv     = ~(o_valid & ~i_ready);
    assign o_ready = adv;

    for (genvar g = 0; g < N; g++) begin : g_lane
        pe_mac_lane #(.DATA_W(DATA_W)) u_lane (
            .clk  (i_clk),
            .rst_n(i_rst_n),
            .en   (adv),
            .a    (i_image [(N-1-g)*DATA_W +: DATA_W]),
            .b    (i_kernel[(N-1-g)*DATA_W +: DATA_W]),
            .prod (prod[g])
        );
    end

    always_comb begin
        prod_sum = '0;
        for (int k = 0; k < N; k++) prod_sum = prod_sum + ACC_W'(prod[k]);
    end

    assign acc_next = (first ? '0 : acc) + sum_q;
    assign acc_ext  = RW'(acc_next);

    // One extra bit keeps the rounding add from wrapping.
    if (ROU > 0) begin : g_rnd
        localparam logic signed [RW-1:0] HALF = RW'(1) << (ROU - 1);
        assign rnd = (acc_ext + HALF) >>> ROU;
    end else begin : g_nornd
        assign rnd = acc_ext;
    end

    assign rr = (relu_pipe[2] && rnd < 0) ? '0 : rnd;

    always_comb begin
        sat_hit = 1'b0;
        sat_val = OUT_W'(rr);
        if (rr > OMAX) begin
            sat_hit = 1'b1;
            sat_val = OUT_W'(OMAX);
        end else if (rr < OMIN) begin
            sat_hit = 1'b1;
            sat_val = OUT_W'(OMIN);
        end
    end

    assign res_load = vld_pipe[2] & last_pipe[2];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            relu_pipe <= '0;
            sum_q     <= '0;
            acc       <= '0;
            first     <= 1'b1;
            o_valid   <= 1'b0;
            o_acc     <= '0;
            o_data    <= '0;
            o_sat     <= 1'b0;
        end else if (adv) begin
            vld_pipe  <= {vld_pipe[1], i_valid};
            last_pipe <= {last_pipe[1], i_last};
            relu_pipe <= {relu_pipe[1], i_relu};
            sum_q     <= prod_sum;
            if (vld_pipe[2]) begin
                acc   <= acc_next;
                first <= last_pipe[2];
            end
            o_valid <= res_load;
            if (res_load) begin
                o_acc  <= acc_next;
                o_data <= sat_val;
                o_sat  <= sat_hit;
            end
        end
    end
endmodule

// File: tb/tb_pe_mac_pipe.sv
// Directed checks for pe_mac_pipe with hand-computed expected results.
module tb_pe_mac_pipe;
    localparam int DW = 8;
    localparam int N  = 18;

    logic                  i_clk = 1'b0;
    logic                  i_rst_n = 1'b1;
    logic                  i_valid = 1'b0;
    logic                  o_ready;
    logic [DW*N-1:0]       i_image = '0;
    logic [DW*N-1:0]       i_kernel = '0;
    logic                  i_last = 1'b0;
    logic                  i_relu = 1'b0;
    logic                  o_valid;
    logic                  i_ready = 1'b1;
    logic signed [23:0]    o_acc;
    logic signed [7:0]     o_data;
    logic                  o_sat;

    int n_chk = 0;
    int n_err = 0;

    pe_mac_pipe dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_image (i_image),
        .i_kernel(i_kernel),
        .i_last  (i_last),
        .i_relu  (i_relu),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_acc   (o_acc),
        .o_data  (o_data),
        .o_sat   (o_sat)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Presents one beat for one rising edge, starting and ending at a negedge.
    task automatic beat(input int img, input int ker, input bit last, input bit relu);
        for (int k = 0; k < N; k++) begin
            i_image [k*DW +: DW] = DW'(img);
            i_kernel[k*DW +: DW] = DW'(ker);
        end
        i_valid = 1'b1;
        i_last  = last;
        i_relu  = relu;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_relu  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int e_acc, input int e_data, input bit e_sat);
        int n = 0;
        while (!o_valid && n < 8) begin
            @(negedge i_clk);
            n++;
        end
        chk({tag, "_vld"}, longint'(o_valid), 1);
        chk({tag, "_acc"}, longint'(o_acc), e_acc);
        chk({tag, "_data"}, longint'(o_data), e_data);
        chk({tag, "_sat"}, longint'(o_sat), e_sat);
        @(negedge i_clk);
    endtask

    initial begin
        int exp_d [4] = '{1, 2, 3, 5};

        #1 i_rst_n = 1'b0;
        #2;
        chk("rst_vld", longint'(o_valid), 0);
        chk("rst_acc", longint'(o_acc), 0);
        chk("rst_data", longint'(o_data), 0);
        chk("rst_sat", longint'(o_sat), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        chk("rst_rdy", longint'(o_ready), 1);
        @(negedge i_clk);

        // all ones, single beat; result two edges after acceptance
        beat(1, 1, 1'b1, 1'b0);
        chk("lat_e0", longint'(o_valid), 0);
        @(negedge i_clk);
        chk("lat_e1", longint'(o_valid), 0);
        @(negedge i_clk);
        chk("lat_e2", longint'(o_valid), 1);
        wait_result("ones", 18, 1, 1'b0);

        // two beats of 127 with idle gap between them
        beat(127, 127, 1'b0, 1'b0);
        repeat (4) begin
            chk("nonlast_vld", longint'(o_valid), 0);
            @(negedge i_clk);
        end
        beat(127, 127, 1'b1, 1'b0);
        wait_result("max2", 580644, 127, 1'b1);

        // most negative products, without and with ReLU
        beat(-128, 127, 1'b1, 1'b0);
        wait_result("neg", -292608, -128, 1'b1);
        beat(-128, 127, 1'b1, 1'b1);
        wait_result("neg_relu", -292608, 0, 1'b0);

        // backpressure: result A held while B waits in the pipe
        beat(1, 1, 1'b1, 1'b0);
        beat(2, 1, 1'b1, 1'b0);
        i_ready = 1'b0;
        @(negedge i_clk);
        repeat (3) begin
            chk("stall_vld", longint'(o_valid), 1);
            chk("stall_rdy", longint'(o_ready), 0);
            chk("stall_acc", longint'(o_acc), 18);
            chk("stall_data", longint'(o_data), 1);
            @(negedge i_clk);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        chk("after_vld", longint'(o_valid), 1);
        chk("after_acc", longint'(o_acc), 36);
        chk("after_data", longint'(o_data), 2);
        @(negedge i_clk);
        chk("after_clr", longint'(o_valid), 0);

        // reset mid-group discards the partial sum
        beat(1, 1, 1'b0, 1'b0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1 chk("mid_rst_vld", longint'(o_valid), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        beat(1, 1, 1'b1, 1'b0);
        wait_result("post_rst", 18, 1, 1'b0);

        // back-to-back single-beat groups
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                for (int k = 0; k < N; k++) begin
                    i_image [k*DW +: DW] = DW'(i + 1);
                    i_kernel[k*DW +: DW] = DW'(1);
                end
                i_valid = 1'b1;
                i_last  = 1'b1;
            end else begin
                i_valid = 1'b0;
                i_last  = 1'b0;
            end
            @(negedge i_clk);
            if (i >= 2) begin
                chk("b2b_vld", longint'(o_valid), 1);
                chk("b2b_acc", longint'(o_acc), 18 * (i - 1));
                chk("b2b_data", longint'(o_data), exp_d[i-2]);
            end
        end
        @(negedge i_clk);
        chk("b2b_end", longint'(o_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
